// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the MEM-stage stall controller: state encoding,
// wait counter width and the default timeout.
package mem_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCESS = 3'd1,
    WAIT   = 3'd2,
    RESP   = 3'd3,
    ERR    = 3'd4
  } stateT;

  localparam int CNT_W           = 4;
  localparam int DEFAULT_TIMEOUT = 15;

  // Saturating increment for the wait counter.
  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/mem_stall_ctrl_if.sv
// Bundle of the pipeline request side and the data-memory side of the
// MEM-stage stall controller.
//
// Handshake: the pipeline raises exactly one of req_rd/req_wr and must hold
// the request stable while pipe_stall=1; the request is consumed on the
// first cycle in which the controller is idle. Toward memory, a one-cycle
// strobe (mem_rd/mem_wr) starts an access; mem_done=1 completes it (and
// wins over mem_stall), mem_stall=1 alone keeps the controller waiting, and
// neither asks for the strobe to be re-issued.
interface mem_stall_ctrl_if #(
  parameter int DATA_W = 16
);
  logic              req_rd;
  logic              req_wr;
  logic [DATA_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              mem_done;
  logic              mem_stall;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rd;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              pipe_stall;
  logic              stage_we;
  logic [DATA_W-1:0] rdata;
  logic              rdata_valid;
  logic              err;
  logic [3:0]        wait_cnt;

  // Controller side.
  modport slave (
    input  req_rd, req_wr, req_addr, req_wdata, mem_done, mem_stall, mem_rdata,
    output mem_rd, mem_wr, mem_addr, mem_wdata, pipe_stall, stage_we,
    output rdata, rdata_valid, err, wait_cnt
  );

  // Pipeline plus memory side.
  modport master (
    output req_rd, req_wr, req_addr, req_wdata, mem_done, mem_stall, mem_rdata,
    input  mem_rd, mem_wr, mem_addr, mem_wdata, pipe_stall, stage_we,
    input  rdata, rdata_valid, err, wait_cnt
  );
endinterface

// File: rtl/reg_en_ar.sv
// Parameter-width register with load enable and asynchronous active-high clear.
module reg_en_ar #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Load d when enabled; clear immediately on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mem_stall_ctrl.sv
// MEM-stage stall controller: takes one read or write at a time, strobes the
// data memory, stalls the pipeline until done or timeout, captures read data.
module mem_stall_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = DEFAULT_TIMEOUT  // legal 1..15
) (
  input  logic            clk,
  input  logic            rst,
  mem_stall_ctrl_if.slave bus,
  output logic [2:0]      dbgState
);

  localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT);
  localparam int               ReqW       = 2 * DATA_W + 1;

  stateT             state;
  logic [CNT_W-1:0]  waitCnt;
  logic              rdataValid;
  logic              errPulse;
  logic              reqOne;
  logic              reqBoth;
  logic              busy;
  logic              dirWr;
  logic              pipeStall;
  logic              reqCapEn;
  logic              rdCapEn;
  logic [ReqW-1:0]   reqQ;
  logic [DATA_W-1:0] rdataQ;

  assign reqOne   = bus.req_rd ^ bus.req_wr;
  assign reqBoth  = bus.req_rd & bus.req_wr;
  assign busy     = (state == ACCESS) || (state == WAIT);
  assign reqCapEn = (state == IDLE) && reqOne;
  assign rdCapEn  = busy && bus.mem_done && !dirWr;

  // Request capture: {direction (1 = write), address, write data}.
  reg_en_ar #(.W(ReqW)) uReqCap (
    .clk (clk),
    .rst (rst),
    .en  (reqCapEn),
    .d   ({bus.req_wr, bus.req_addr, bus.req_wdata}),
    .q   (reqQ)
  );

  assign dirWr = reqQ[ReqW-1];

  // Read data capture; holds until the next read completes.
  reg_en_ar #(.W(DATA_W)) uRdataCap (
    .clk (clk),
    .rst (rst),
    .en  (rdCapEn),
    .d   (bus.mem_rdata),
    .q   (rdataQ)
  );

  // Access sequencing, wait counting and the registered response pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      waitCnt    <= '0;
      rdataValid <= 1'b0;
      errPulse   <= 1'b0;
    end else begin
      rdataValid <= 1'b0;
      errPulse   <= 1'b0;
      case (state)
        IDLE: begin
          if (reqBoth) begin
            state    <= ERR;
            errPulse <= 1'b1;
          end else if (reqOne) begin
            state <= ACCESS;
          end
        end
        ACCESS, WAIT: begin
          waitCnt <= satInc(waitCnt);
          if (bus.mem_done) begin
            state      <= RESP;
            rdataValid <= !dirWr;
          end else if (waitCnt == TimeoutCnt) begin
            state    <= ERR;
            errPulse <= 1'b1;
          end else if (state == ACCESS) begin
            state <= WAIT;
          end else if (!bus.mem_stall) begin
            state <= ACCESS;
          end
        end
        RESP, ERR: begin
          state   <= IDLE;
          waitCnt <= '0;
        end
        default: begin
          state   <= IDLE;
          waitCnt <= '0;
        end
      endcase
    end
  end

  // Stall is raised in the request cycle itself and held through the access.
  assign pipeStall = (state == IDLE) ? reqOne : busy;

  assign bus.pipe_stall  = pipeStall;
  assign bus.stage_we    = ~pipeStall;
  assign bus.mem_rd      = (state == ACCESS) && !dirWr;
  assign bus.mem_wr      = (state == ACCESS) && dirWr;
  assign bus.mem_addr    = reqQ[2*DATA_W-1:DATA_W];
  assign bus.mem_wdata   = reqQ[DATA_W-1:0];
  assign bus.rdata       = rdataQ;
  assign bus.rdata_valid = rdataValid;
  assign bus.err         = errPulse;
  assign bus.wait_cnt    = waitCnt;
  assign dbgState        = state;

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// Bench for mem_stall_ctrl: reset check, table of cycle vectors, hand-written
// timeout and reset sequences, then randomized transactions against a
// transaction-level reference model.
module tb_mem_stall_ctrl;

  localparam int DW = 16;
  localparam int TO = 4;
  localparam int EW = 6 + 4 + 3 * DW;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] dbgState;

  int checks   = 0;
  int failures = 0;

  logic [EW-1:0] expQ[$];

  // Model view of the registered request and the last read word.
  logic [DW-1:0] mAddr  = '0;
  logic [DW-1:0] mWdata = '0;
  logic [DW-1:0] mRdata = '0;

  typedef struct {
    string         name;
    logic          rd;
    logic          wr;
    logic [DW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          done;
    logic          stall;
    logic [DW-1:0] mrd;
    logic [EW-1:0] expW;
  } vecT;

  vecT vecs[$];

  mem_stall_ctrl_if #(.DATA_W(DW)) bus ();

  mem_stall_ctrl #(.DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .dbgState (dbgState)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [EW-1:0] packExp(input logic st, srd, swr, v, e,
                                            input logic [3:0] cnt,
                                            input logic [DW-1:0] a, wd, rdt);
    return {st, ~st, srd, swr, v, e, cnt, a, wd, rdt};
  endfunction

  function automatic logic [EW-1:0] actWord();
    return {bus.pipe_stall, bus.stage_we, bus.mem_rd, bus.mem_wr, bus.rdata_valid,
            bus.err, bus.wait_cnt, bus.mem_addr, bus.mem_wdata, bus.rdata};
  endfunction

  function automatic logic [3:0] cntOf(input int x);
    return (x > 15) ? 4'd15 : 4'(x);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, wr, input logic [DW-1:0] a, wd,
                       input logic dn, sl, input logic [DW-1:0] mr);
    bus.req_rd    = rd;
    bus.req_wr    = wr;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    bus.mem_done  = dn;
    bus.mem_stall = sl;
    bus.mem_rdata = mr;
  endtask

  task automatic driveNoise();
    drive(1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
          1'($urandom), 1'($urandom), 16'($urandom));
  endtask

  task automatic checkVal(input string tag, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h", tag, act, expv);
    end
  endtask

  // Scoreboard: compare the current outputs against the head of expQ.
  task automatic checkCycle(input string tag);
    logic [EW-1:0] expW;
    logic [EW-1:0] act;
    @(negedge clk);
    act = actWord();
    checks++;
    if (expQ.size() == 0) begin
      failures++;
      $display("FAIL %s: no expected entry, actual=%h", tag, act);
    end else begin
      expW = expQ.pop_front();
      if (act !== expW) begin
        failures++;
        $display("FAIL %s: actual=%h expected=%h", tag, act, expW);
      end
    end
    tick();
  endtask

  task automatic expCycle(input string tag, input logic st, srd, swr, v, e,
                          input logic [3:0] cnt);
    expQ.push_back(packExp(st, srd, swr, v, e, cnt, mAddr, mWdata, mRdata));
    checkCycle(tag);
  endtask

  task automatic addVec(input string name, input logic rd, wr,
                        input logic [DW-1:0] a, wd, input logic dn, sl,
                        input logic [DW-1:0] mr, input logic st, srd, swr, v, e,
                        input logic [3:0] cnt, input logic [DW-1:0] ea, ewd, erd);
    vecT t;
    t.name = name; t.rd = rd; t.wr = wr; t.addr = a; t.wdata = wd;
    t.done = dn; t.stall = sl; t.mrd = mr;
    t.expW = packExp(st, srd, swr, v, e, cnt, ea, ewd, erd);
    vecs.push_back(t);
  endtask

  // One random transaction: optional idle gap, then a read, write or illegal request.
  task automatic randTxn();
    int            kind;
    int            r;
    logic          isRd;
    logic          strobe;
    logic          dn;
    logic          sl;
    logic [DW-1:0] a;
    logic [DW-1:0] wd;
    logic [DW-1:0] mr;
    repeat ($urandom_range(0, 2)) begin
      drive(1'b0, 1'b0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 16'($urandom));
      expCycle("rnd_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    end
    kind = $urandom_range(0, 9);
    a    = 16'($urandom);
    wd   = 16'($urandom);
    if (kind == 0) begin
      drive(1'b1, 1'b1, a, wd, 1'($urandom), 1'($urandom), 16'($urandom));
      expCycle("rnd_ill_req", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
      driveNoise();
      expCycle("rnd_ill_err", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
    end else begin
      isRd = (kind <= 5);
      drive(isRd, !isRd, a, wd, 1'($urandom), 1'($urandom), 16'($urandom));
      expCycle("rnd_req", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
      mAddr  = a;
      mWdata = wd;
      strobe = 1'b1;
      // Cycle k of the access shows k-1 elapsed cycles.
      for (int k = 1; k <= TO + 1; k++) begin
        r  = $urandom_range(0, 9);
        dn = (r <= 2);
        sl = (r == 2) || (r >= 3 && r <= 6);
        mr = 16'($urandom);
        drive(isRd, !isRd, a, wd, dn, sl, mr);
        expCycle("rnd_busy", 1'b1, strobe & isRd, strobe & !isRd, 1'b0, 1'b0, cntOf(k - 1));
        if (dn) begin
          if (isRd) mRdata = mr;
          driveNoise();
          expCycle("rnd_resp", 1'b0, 1'b0, 1'b0, isRd, 1'b0, cntOf(k));
          break;
        end else if (k - 1 == TO) begin
          driveNoise();
          expCycle("rnd_timeout", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, cntOf(k));
          break;
        end
        // A strobe is issued first and again after each non-stalled wait cycle.
        strobe = !strobe && !sl;
      end
    end
  endtask

  initial begin
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0);

    // Reset state
    @(negedge clk);
    checkVal("reset_pipe_stall", 32'(bus.pipe_stall), 32'd0);
    checkVal("reset_stage_we", 32'(bus.stage_we), 32'd1);
    checkVal("reset_mem_rd", 32'(bus.mem_rd), 32'd0);
    checkVal("reset_mem_wr", 32'(bus.mem_wr), 32'd0);
    checkVal("reset_rdata_valid", 32'(bus.rdata_valid), 32'd0);
    checkVal("reset_err", 32'(bus.err), 32'd0);
    checkVal("reset_wait_cnt", 32'(bus.wait_cnt), 32'd0);
    checkVal("reset_mem_addr", 32'(bus.mem_addr), 32'd0);
    checkVal("reset_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    checkVal("reset_rdata", 32'(bus.rdata), 32'd0);
    checkVal("reset_state", 32'(dbgState), 32'd0);
    tick();
    rst = 1'b0;

    // Vector table: inputs | stall rd wr valid err cnt addr wdata rdata
    addVec("rd_req",     1,0,16'h0010,16'h0000,0,0,16'h0000, 1,0,0,0,0,4'd0,16'h0000,16'h0000,16'h0000);
    addVec("rd_access",  1,0,16'h0010,16'h0000,1,0,16'h1234, 1,1,0,0,0,4'd0,16'h0010,16'h0000,16'h0000);
    addVec("rd_resp",    0,0,16'h0000,16'h0000,0,0,16'h0000, 0,0,0,1,0,4'd1,16'h0010,16'h0000,16'h1234);
    addVec("rd_idle",    0,0,16'h0000,16'h0000,0,0,16'h0000, 0,0,0,0,0,4'd0,16'h0010,16'h0000,16'h1234);
    addVec("wr_req",     0,1,16'h00F0,16'hBEEF,0,0,16'h0000, 1,0,0,0,0,4'd0,16'h0010,16'h0000,16'h1234);
    addVec("wr_access",  0,1,16'h00F0,16'hBEEF,0,1,16'h0000, 1,0,1,0,0,4'd0,16'h00F0,16'hBEEF,16'h1234);
    addVec("wr_wait1",   0,1,16'h00F0,16'hBEEF,0,1,16'h0000, 1,0,0,0,0,4'd1,16'h00F0,16'hBEEF,16'h1234);
    addVec("wr_wait2",   0,1,16'h00F0,16'hBEEF,0,1,16'h0000, 1,0,0,0,0,4'd2,16'h00F0,16'hBEEF,16'h1234);
    addVec("wr_done",    0,1,16'h00F0,16'hBEEF,1,0,16'hDEAD, 1,0,0,0,0,4'd3,16'h00F0,16'hBEEF,16'h1234);
    addVec("wr_resp",    0,0,16'h0000,16'h0000,0,0,16'h0000, 0,0,0,0,0,4'd4,16'h00F0,16'hBEEF,16'h1234);
    addVec("wr_idle",    0,0,16'h0000,16'h0000,0,0,16'h0000, 0,0,0,0,0,4'd0,16'h00F0,16'hBEEF,16'h1234);
    addVec("both_req",   1,1,16'hAAAA,16'h5555,0,0,16'h0000, 0,0,0,0,0,4'd0,16'h00F0,16'hBEEF,16'h1234);
    addVec("both_err",   0,0,16'h0000,16'h0000,0,0,16'h0000, 0,0,0,0,1,4'd0,16'h00F0,16'hBEEF,16'h1234);
    addVec("both_idle",  0,0,16'h0000,16'h0000,0,0,16'h0000, 0,0,0,0,0,4'd0,16'h00F0,16'hBEEF,16'h1234);
    addVec("ds_req",     1,0,16'h0042,16'h0000,0,0,16'h0000, 1,0,0,0,0,4'd0,16'h00F0,16'hBEEF,16'h1234);
    addVec("ds_access",  1,0,16'h0042,16'h0000,1,1,16'h5A5A, 1,1,0,0,0,4'd0,16'h0042,16'h0000,16'h1234);
    addVec("ds_resp",    0,0,16'h0000,16'h0000,0,0,16'h0000, 0,0,0,1,0,4'd1,16'h0042,16'h0000,16'h5A5A);
    addVec("rt_req",     1,0,16'h0100,16'h0007,0,0,16'h0000, 1,0,0,0,0,4'd0,16'h0042,16'h0000,16'h5A5A);
    addVec("rt_access1", 1,0,16'h0100,16'h0007,0,0,16'h0000, 1,1,0,0,0,4'd0,16'h0100,16'h0007,16'h5A5A);
    addVec("rt_wait",    1,0,16'h0100,16'h0007,0,0,16'h0000, 1,0,0,0,0,4'd1,16'h0100,16'h0007,16'h5A5A);
    addVec("rt_access2", 1,0,16'h0100,16'h0007,1,0,16'h0F0F, 1,1,0,0,0,4'd2,16'h0100,16'h0007,16'h5A5A);
    addVec("rt_resp",    1,1,16'hFFFF,16'hFFFF,0,0,16'h0000, 0,0,0,1,0,4'd3,16'h0100,16'h0007,16'h0F0F);
    addVec("rt_idle",    0,0,16'h0000,16'h0000,0,0,16'h0000, 0,0,0,0,0,4'd0,16'h0100,16'h0007,16'h0F0F);

    foreach (vecs[i]) begin
      drive(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
            vecs[i].done, vecs[i].stall, vecs[i].mrd);
      expQ.push_back(vecs[i].expW);
      checkCycle(vecs[i].name);
    end

    // Timeout: memory never answers, TIMEOUT=4
    drive(1'b1, 1'b0, 16'h0200, 16'h0000, 1'b0, 1'b0, 16'h0000);
    @(negedge clk);
    checkVal("to_req_stall", 32'(bus.pipe_stall), 32'd1);
    tick();
    for (int k = 1; k <= 5; k++) begin
      drive(1'b1, 1'b0, 16'h0200, 16'h0000, 1'b0, 1'b0, 16'($urandom));
      @(negedge clk);
      checkVal($sformatf("to_strobe_%0d", k), 32'(bus.mem_rd), 32'(k % 2));
      checkVal($sformatf("to_cnt_%0d", k), 32'(bus.wait_cnt), 32'(k - 1));
      checkVal($sformatf("to_stall_%0d", k), 32'(bus.pipe_stall), 32'd1);
      tick();
    end
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0);
    @(negedge clk);
    checkVal("to_err", 32'(bus.err), 32'd1);
    checkVal("to_stall_drop", 32'(bus.pipe_stall), 32'd0);
    checkVal("to_stage_we", 32'(bus.stage_we), 32'd1);
    checkVal("to_rdata_kept", 32'(bus.rdata), 32'h0F0F);
    checkVal("to_no_valid", 32'(bus.rdata_valid), 32'd0);
    tick();
    @(negedge clk);
    checkVal("to_err_pulse", 32'(bus.err), 32'd0);
    checkVal("to_idle_state", 32'(dbgState), 32'd0);
    checkVal("to_cnt_clear", 32'(bus.wait_cnt), 32'd0);
    tick();

    // Reset in ACCESS drops the strobe without a clock edge
    drive(1'b1, 1'b0, 16'h0400, 16'h0000, 1'b0, 1'b0, '0);
    tick();
    @(negedge clk);
    checkVal("arst_pre_rd", 32'(bus.mem_rd), 32'd1);
    #2;
    rst = 1'b1;
    bus.req_rd = 1'b0;
    #1;
    checkVal("arst_rd_drop", 32'(bus.mem_rd), 32'd0);
    checkVal("arst_stall_drop", 32'(bus.pipe_stall), 32'd0);
    tick();
    rst = 1'b0;

    // Reset in WAIT, then mem_done is ignored
    drive(1'b0, 1'b1, 16'h0300, 16'h1111, 1'b0, 1'b0, '0);
    tick();
    drive(1'b0, 1'b1, 16'h0300, 16'h1111, 1'b0, 1'b1, '0);
    @(negedge clk);
    checkVal("rst_pre_wr", 32'(bus.mem_wr), 32'd1);
    tick();
    @(negedge clk);
    checkVal("rst_wait_cnt", 32'(bus.wait_cnt), 32'd1);
    #2;
    rst = 1'b1;
    bus.req_wr = 1'b0;
    #1;
    checkVal("rst_stall", 32'(bus.pipe_stall), 32'd0);
    checkVal("rst_mem_wr", 32'(bus.mem_wr), 32'd0);
    checkVal("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    checkVal("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    checkVal("rst_cnt", 32'(bus.wait_cnt), 32'd0);
    checkVal("rst_rdata", 32'(bus.rdata), 32'd0);
    checkVal("rst_state", 32'(dbgState), 32'd0);
    bus.mem_done  = 1'b1;
    bus.mem_rdata = 16'hCAFE;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checkVal("rst_done_no_valid", 32'(bus.rdata_valid), 32'd0);
    checkVal("rst_done_no_stall", 32'(bus.pipe_stall), 32'd0);
    tick();
    bus.mem_done = 1'b0;
    @(negedge clk);
    checkVal("rst_done_rdata", 32'(bus.rdata), 32'd0);
    checkVal("rst_done_valid", 32'(bus.rdata_valid), 32'd0);
    checkVal("rst_done_state", 32'(dbgState), 32'd0);
    tick();

    // Randomized transactions against the reference model
    mAddr  = '0;
    mWdata = '0;
    mRdata = '0;
    for (int n = 0; n < 200; n++) begin
      randTxn();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stall_ctrl.md
# mem_stall_ctrl

Handshake controller between the MEM pipeline stage and the stalling data memory. Accepts one read or write request at a time, drives the memory strobes, and holds the pipeline stalled until the memory reports done or a wait-cycle timeout expires. On reads it captures the returned word. It produces the write-enable that lets the downstream MEM/WB enabled registers advance.

## Interface
Parameters:
- `DATA_W`, default 16: data and address width.
- `TIMEOUT`, default 15: maximum ACCESS+WAIT cycles before error; legal range 1..15 (4-bit counter).

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_rd`  in  1  MEM stage read request; held stable by the pipeline while `pipe_stall`=1.
- `req_wr`  in  1  MEM stage write request; same hold rule.
- `req_addr`  in  DATA_W  request address.
- `req_wdata`  in  DATA_W  write data.
- `mem_done`  in  1  memory completed the access this cycle.
- `mem_stall`  in  1  memory busy; access must be retried.
- `mem_rdata`  in  DATA_W  read data, valid when `mem_done`=1.
- `mem_rd`, `mem_wr`  out  1  memory strobes.
- `mem_addr`, `mem_wdata`  out  DATA_W  registered request address and data.
- `pipe_stall`  out  1  freeze the pipeline.
- `stage_we`  out  1  write-enable for the MEM/WB registers (= ~`pipe_stall`).
- `rdata`  out  DATA_W  captured read data.
- `rdata_valid`  out  1  one-cycle pulse; `rdata` is valid.
- `err`  out  1  one-cycle pulse on timeout or illegal request.
- `wait_cnt`  out  4  cycles spent in the current access.

## Operation
- States: IDLE, ACCESS, WAIT, RESP, ERR.
- IDLE:
  - `req_rd` xor `req_wr`: register addr, wdata and direction; `pipe_stall`=1 combinationally in the same cycle; next state ACCESS.
  - Both requests high: illegal; next state ERR with no memory access.
  - Neither high: stay in IDLE; `pipe_stall`=0.
- ACCESS:
  - Assert `mem_rd` or `mem_wr` from the registered direction; `wait_cnt`++.
  - `mem_done`: capture `mem_rdata` on a read; next state RESP.
  - Otherwise: next state WAIT.
- WAIT:
  - Strobes low; `wait_cnt`++.
  - `mem_done`: capture and go to RESP.
  - Neither `mem_done` nor `mem_stall`: retry via ACCESS.
  - `mem_stall` only: stay in WAIT.
- Timeout: in ACCESS or WAIT, `wait_cnt`==TIMEOUT and no `mem_done` takes priority over all other transitions; next state ERR.
- RESP:
  - `pipe_stall`=0.
  - `rdata_valid`=1 for reads only.
  - Next state IDLE; `wait_cnt` cleared.
- ERR: `err`=1, `pipe_stall`=0, `rdata` unchanged; next state IDLE; `wait_cnt` cleared.
- `mem_done` and `mem_stall` high together: done wins.
- Requests in any state other than IDLE are ignored.
- `wait_cnt` saturates at 15.
- `rdata` holds its value until the next read completes.

## Timing
- Reset values: state IDLE; `mem_rd`/`mem_wr`/`rdata_valid`/`err`=0; `rdata`/`mem_addr`/`mem_wdata`/`wait_cnt`=0.
- `pipe_stall`=0 in IDLE with no request.
- Reset asserted mid-access drops strobes immediately, without waiting for a clock edge. Any later `mem_done` is ignored.
- Best case (done in the first ACCESS cycle):
  - Request at cycle T0; strobe at T1; RESP at T2.
  - `pipe_stall` high for T0–T1; `stage_we`=1 at T2.
- Each extra memory wait cycle adds one cycle of stall.
- Back-to-back requests: the next request is sampled in IDLE at T3 at the earliest; no overlap.
- `rdata`, `rdata_valid` and `err` are registered outputs. `pipe_stall`, `stage_we` and the strobes are decoded from state plus the IDLE request inputs.

## Structure
- Shared package `mem_ctrl_pkg` holds:
  - state encoding constants (3-bit: IDLE=0, ACCESS=1, WAIT=2, RESP=3, ERR=4);
  - the default TIMEOUT.
- One natural sub-module: `reg_en_ar`, a parameter-width enabled register with asynchronous active-high reset.
  - Instance 1: request capture (addr, wdata, direction).
  - Instance 2: `rdata` capture.
- FSM and counter stay in the top module.

## Test plan
- Read, `mem_done` in the first ACCESS cycle, `mem_rdata`=0x1234: `mem_rd` for 1 cycle, stall for 2 cycles, `rdata`=0x1234 with `rdata_valid` in the 3rd cycle.
- Write to addr 0x00F0, data 0xBEEF, with `mem_stall` for 3 cycles then `mem_done`: `mem_wdata`=0xBEEF held throughout, `rdata_valid` stays 0, `wait_cnt` reaches 4, stall ends the cycle after done.
- TIMEOUT=4, memory never responds: `err` pulses on cycle 6 after the request, `pipe_stall` drops, state returns to IDLE, `rdata` unchanged.
- `req_rd` and `req_wr` both high: no strobe, `err` pulse the next cycle.
- `rst` asserted during WAIT, then `mem_done`: all outputs 0 immediately, done ignored, IDLE after release.
- `mem_done` and `mem_stall` high together in ACCESS: treated as done, RESP the next cycle.
